// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX result, waits for the data-SRAM load response,
// aligns/extends load data and presents one registered result per instruction to WB.
module mem_stage #(
    parameter int ZIP_IN_W  = 106,
    parameter int ZIP_OUT_W = 103,
    parameter int EXC_W     = 82
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EX_valid,
    input  logic [ZIP_IN_W-1:0]  EX_to_MEM_zip,
    input  logic [EXC_W-1:0]     EX_except_zip,
    output logic                 MEM_allowin,
    input  logic                 WB_allowin,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 flush,
    output logic [ZIP_OUT_W-1:0] MEM_to_WB_zip,
    output logic [EXC_W-1:0]     MEM_except_reg,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t                state;
    logic                  ms_valid;
    logic [ZIP_IN_W-1:0]   ex_zip_r;
    logic [EXC_W-1:0]      exc_r;
    logic [31:0]           ld_buf;

    logic [31:0] pc;
    logic [31:0] ir;
    logic        gr_we;
    logic [4:0]  rf_waddr;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic [31:0] alu_result;

    assign pc           = ex_zip_r[105:74];
    assign ir           = ex_zip_r[73:42];
    assign gr_we        = ex_zip_r[41];
    assign rf_waddr     = ex_zip_r[40:36];
    assign res_from_mem = ex_zip_r[35];
    assign ld_op        = ex_zip_r[34:32];
    assign alu_result   = ex_zip_r[31:0];

    // Handshake: EX payload moves in when EX_valid & MEM_allowin & ~flush at a posedge;
    // MEM hands off to WB when ms_valid & ms_ready_go & WB_allowin & ~flush.
    logic load_in_mem;
    logic ms_ready_go;
    logic accept;
    logic complete;

    assign load_in_mem = ms_valid & res_from_mem;
    assign ms_ready_go = ~res_from_mem | data_sram_data_ok | (state == HOLD);
    assign MEM_allowin = (state != DISCARD) & (~ms_valid | (ms_ready_go & WB_allowin));
    assign accept      = EX_valid & MEM_allowin & ~flush;
    assign complete    = ms_valid & ms_ready_go & WB_allowin & ~flush;
    assign dbg_state   = state;

    logic [31:0] raw_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign raw_data = (state == HOLD) ? ld_buf : data_sram_rdata;

    always_comb begin
        byte_sel = raw_data[7:0];
        case (alu_result[1:0])
            2'd0: byte_sel = raw_data[7:0];
            2'd1: byte_sel = raw_data[15:8];
            2'd2: byte_sel = raw_data[23:16];
            2'd3: byte_sel = raw_data[31:24];
            default: byte_sel = raw_data[7:0];
        endcase
        half_sel = alu_result[1] ? raw_data[31:16] : raw_data[15:0];
        case (ld_op)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b101:  load_data = {24'd0, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b110:  load_data = {16'd0, half_sel};
            default: load_data = raw_data;
        endcase
        rf_wdata = res_from_mem ? load_data : alu_result;
    end

    // A flushed load whose request is still outstanding sends us to DISCARD so its
    // late response cannot be mistaken for the next load's data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ld_buf <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_in_mem) begin
                        if (flush) begin
                            state <= data_sram_data_ok ? IDLE : DISCARD;
                        end else if (!data_sram_data_ok) begin
                            state <= WAIT;
                        end else if (!WB_allowin) begin
                            state  <= HOLD;
                            ld_buf <= data_sram_rdata;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= data_sram_data_ok ? IDLE : DISCARD;
                    end else if (data_sram_data_ok) begin
                        if (WB_allowin) begin
                            state <= IDLE;
                        end else begin
                            state  <= HOLD;
                            ld_buf <= data_sram_rdata;
                        end
                    end
                end
                HOLD: begin
                    if (flush || WB_allowin) state <= IDLE;
                end
                DISCARD: begin
                    if (data_sram_data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_valid <= 1'b0;
            ex_zip_r <= '0;
            exc_r    <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (MEM_allowin) begin
                ms_valid <= EX_valid;
            end
            if (accept) begin
                ex_zip_r <= EX_to_MEM_zip;
                exc_r    <= EX_except_zip;
            end
        end
    end

    // Valid bit drops after one cycle so WB sees each instruction exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_to_WB_zip  <= '0;
            MEM_except_reg <= '0;
        end else if (complete) begin
            MEM_to_WB_zip  <= {1'b1, pc, ir, gr_we, rf_waddr, rf_wdata};
            MEM_except_reg <= exc_r;
        end else begin
            MEM_to_WB_zip[ZIP_OUT_W-1] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked with immediate assertions.
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic         EX_valid;
    logic [105:0] EX_to_MEM_zip;
    logic [81:0]  EX_except_zip;
    logic         MEM_allowin;
    logic         WB_allowin;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         flush;
    logic [102:0] MEM_to_WB_zip;
    logic [81:0]  MEM_except_reg;
    logic [1:0]   dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .EX_valid          (EX_valid),
        .EX_to_MEM_zip     (EX_to_MEM_zip),
        .EX_except_zip     (EX_except_zip),
        .MEM_allowin       (MEM_allowin),
        .WB_allowin        (WB_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .MEM_to_WB_zip     (MEM_to_WB_zip),
        .MEM_except_reg    (MEM_except_reg),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [105:0] mk_zip(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic we, input logic [4:0] wa,
                                            input logic rm, input logic [2:0] op,
                                            input logic [31:0] alu);
        return {pc, ir, we, wa, rm, op, alu};
    endfunction

    function automatic logic [102:0] mk_out(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        return {1'b1, pc, ir, we, wa, wd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [105:0] z, input logic [81:0] e);
        EX_valid      = 1'b1;
        EX_to_MEM_zip = z;
        EX_except_zip = e;
    endtask

    logic [102:0] e_out;
    logic [81:0]  exc1;
    logic [81:0]  exc6;

    initial begin
        exc1 = 82'h2_1111_2222_3333_4444_0055;
        exc6 = 82'h1_AAAA_5555_0F0F_1234_3003;
        rst = 1'b0;
        EX_valid = 1'b0;
        EX_to_MEM_zip = '0;
        EX_except_zip = '0;
        WB_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        flush = 1'b0;
        #1;
        check("reset_zip", MEM_to_WB_zip, 0);
        check("reset_exc", MEM_except_reg, 0);
        check("reset_state", dbg_state, 0);
        check("reset_allowin", MEM_allowin, 1);
        tick();
        tick();
        rst = 1'b1;

        // 1: add passes through in one cycle, shown to WB for one cycle
        tick();
        offer(mk_zip(32'h1000, 32'h0010_0001, 1'b1, 5'd5, 1'b0, 3'b000, 32'h1234_5678), exc1);
        tick();
        EX_valid = 1'b0;
        check("add_not_yet", MEM_to_WB_zip[102], 0);
        tick();
        e_out = mk_out(32'h1000, 32'h0010_0001, 1'b1, 5'd5, 32'h1234_5678);
        check("add_out", MEM_to_WB_zip, e_out);
        check("add_exc", MEM_except_reg, exc1);
        tick();
        e_out[102] = 1'b0;
        check("add_drop_valid", MEM_to_WB_zip, e_out);

        // 2: ld.b byte 3, response three cycles late
        offer(mk_zip(32'h1004, 32'h2800_0001, 1'b1, 5'd6, 1'b1, 3'b001, 32'h0000_0103), '0);
        tick();
        EX_valid = 1'b0;
        #1 check("ldb_stall1", MEM_allowin, 0);
        tick();
        check("ldb_wait_state", dbg_state, 1);
        check("ldb_stall2", MEM_allowin, 0);
        tick();
        check("ldb_stall3", MEM_allowin, 0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80AA_BB00;
        #1 check("ldb_allow_on_ok", MEM_allowin, 1);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        check("ldb_out", MEM_to_WB_zip, mk_out(32'h1004, 32'h2800_0001, 1'b1, 5'd6, 32'hFFFF_FF80));
        check("ldb_idle", dbg_state, 0);

        // 3: ld.hu half 1, response while WB stalls, served from the buffer
        offer(mk_zip(32'h1008, 32'h2A40_0002, 1'b1, 5'd7, 1'b1, 3'b110, 32'h0000_0102), '0);
        tick();
        EX_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hF00D_0001;
        WB_allowin = 1'b0;
        #1 check("ldhu_wb_stall", MEM_allowin, 0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        check("ldhu_hold_state", dbg_state, 2);
        check("ldhu_no_out", MEM_to_WB_zip[102], 0);
        WB_allowin = 1'b1;
        #1 check("ldhu_allow_hold", MEM_allowin, 1);
        tick();
        check("ldhu_out", MEM_to_WB_zip, mk_out(32'h1008, 32'h2A40_0002, 1'b1, 5'd7, 32'h0000_F00D));
        check("ldhu_idle", dbg_state, 0);

        // 4: flush during WAIT, late response discarded
        offer(mk_zip(32'h100C, 32'h2880_0003, 1'b1, 5'd8, 1'b1, 3'b000, 32'h0000_0040), '0);
        tick();
        EX_valid = 1'b0;
        tick();
        check("flush_wait_state", dbg_state, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_discard_state", dbg_state, 3);
        check("flush_discard_allowin", MEM_allowin, 0);
        check("flush_no_out", MEM_to_WB_zip[102], 0);
        tick();
        check("discard_still", dbg_state, 3);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_5555;
        #1 check("discard_allowin_on_ok", MEM_allowin, 0);
        tick();
        data_sram_data_ok = 1'b0;
        check("discard_done_state", dbg_state, 0);
        check("discard_done_allowin", MEM_allowin, 1);
        check("discard_no_out", MEM_to_WB_zip[102], 0);

        // flush blocks an EX instruction offered in the same cycle
        offer(mk_zip(32'h1030, 32'h0010_0004, 1'b1, 5'd9, 1'b0, 3'b000, 32'h0000_0099), '0);
        flush = 1'b1;
        tick();
        EX_valid = 1'b0;
        flush = 1'b0;
        tick();
        check("flush_blocks_accept", MEM_to_WB_zip[102], 0);

        // 5: asynchronous reset while a load waits
        offer(mk_zip(32'h1010, 32'h2880_0005, 1'b1, 5'd10, 1'b1, 3'b000, 32'h0000_0080), '0);
        tick();
        EX_valid = 1'b0;
        tick();
        check("pre_reset_wait", dbg_state, 1);
        rst = 1'b0;
        #1;
        check("areset_zip", MEM_to_WB_zip, 0);
        check("areset_exc", MEM_except_reg, 0);
        check("areset_state", dbg_state, 0);
        check("areset_allowin", MEM_allowin, 1);
        rst = 1'b1;
        offer(mk_zip(32'h1014, 32'h0010_0006, 1'b1, 5'd11, 1'b0, 3'b000, 32'hCAFE_F00D), '0);
        tick();
        EX_valid = 1'b0;
        tick();
        check("post_reset_add", MEM_to_WB_zip, mk_out(32'h1014, 32'h0010_0006, 1'b1, 5'd11, 32'hCAFE_F00D));

        // 6: back-to-back ld.w / add / ld.w
        offer(mk_zip(32'h1018, 32'h2880_0007, 1'b1, 5'd12, 1'b1, 3'b000, 32'h0000_0003), exc6);
        tick();
        offer(mk_zip(32'h101C, 32'h0010_0008, 1'b1, 5'd13, 1'b0, 3'b000, 32'h0000_0077), '0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_2222;
        #1 check("b2b_allow1", MEM_allowin, 1);
        tick();
        offer(mk_zip(32'h1020, 32'h2880_0009, 1'b0, 5'd14, 1'b1, 3'b000, 32'h0000_0000), '0);
        data_sram_data_ok = 1'b0;
        check("b2b_ld1", MEM_to_WB_zip, mk_out(32'h1018, 32'h2880_0007, 1'b1, 5'd12, 32'h1111_2222));
        check("b2b_ld1_exc", MEM_except_reg, exc6);
        tick();
        EX_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h3333_4444;
        check("b2b_add", MEM_to_WB_zip, mk_out(32'h101C, 32'h0010_0008, 1'b1, 5'd13, 32'h0000_0077));
        tick();
        data_sram_data_ok = 1'b0;
        check("b2b_ld2", MEM_to_WB_zip, mk_out(32'h1020, 32'h2880_0009, 1'b0, 5'd14, 32'h3333_4444));
        tick();
        check("b2b_end_valid", MEM_to_WB_zip[102], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
